// File: rtl/mon_exp_ctrl.sv
// rtl/mon_exp_ctrl.sv - left-to-right binary modular exponentiation sequencer driving a Montgomery multiplier
//
// Purpose:
//   Walks the exponent MSB first. For each bit it requests one Montgomery square
//   and, when the bit is set, one Montgomery multiply by the base. The products
//   come back from an external multiplier and are used unchanged. No arithmetic
//   is done here.
//
// Optional feature (macro MON_EXP_FROM_MONT_EN):
//   When defined, one extra MonPro(acc, 1) takes the result out of the Montgomery
//   domain (result = X^E mod M). When undefined, the CONV states are not built
//   and the result stays in Montgomery form (X^E * R mod M).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 single-cycle request, sampled only in IDLE
//   base, r_mod, exp, mod base (Montgomery form), R mod M, exponent, odd modulus
//   busy, done, result    status and result (result valid only while done = 1)
//   mp_opA/B/M            registered multiplier operands, held until the response
//   mp_in_valid           one-cycle multiplier request pulse
//   mp_out_data/valid     multiplier product and response strobe

module mon_exp_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int E_WIDTH    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [DATA_WIDTH-1:0] r_mod,
    input  logic [E_WIDTH-1:0]    exp,
    input  logic [DATA_WIDTH-1:0] mod,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic [DATA_WIDTH-1:0] mp_opA,
    output logic [DATA_WIDTH-1:0] mp_opB,
    output logic [DATA_WIDTH-1:0] mp_opM,
    output logic                  mp_in_valid,
    input  logic [DATA_WIDTH-1:0] mp_out_data,
    input  logic                  mp_out_valid
);

    localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(E_WIDTH - 1);
`ifdef MON_EXP_FROM_MONT_EN
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SQR_REQ  = 3'd1,
        S_SQR_WAIT = 3'd2,
        S_MUL_REQ  = 3'd3,
        S_MUL_WAIT = 3'd4,
`ifdef MON_EXP_FROM_MONT_EN
        S_CONV_REQ  = 3'd5,
        S_CONV_WAIT = 3'd6,
`endif
        S_DONE     = 3'd7
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_base_q;
    logic [E_WIDTH-1:0]    r_exp_q;
    logic [IW-1:0]         r_idx;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mp_opA;
    logic [DATA_WIDTH-1:0] r_mp_opB;
    logic [DATA_WIDTH-1:0] r_mp_opM;
    logic                  r_mp_in_valid;

    // Requests are launched on the transition into a REQ state, so mp_in_valid
    // is high exactly during the REQ-state cycle and the operands are already
    // in place. Next operands are taken straight from mp_out_data because
    // r_acc only receives that value on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_base_q      <= '0;
            r_exp_q       <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mp_opA      <= '0;
            r_mp_opB      <= '0;
            r_mp_opM      <= '0;
            r_mp_in_valid <= 1'b0;
        end else begin
            r_mp_in_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base_q      <= base;
                        r_exp_q       <= exp;
                        r_acc         <= r_mod;
                        r_idx         <= IDX_TOP;
                        r_busy        <= 1'b1;
                        r_mp_opA      <= r_mod;
                        r_mp_opB      <= r_mod;
                        r_mp_opM      <= mod;
                        r_mp_in_valid <= 1'b1;
                        r_state       <= S_SQR_REQ;
                    end
                end
                S_SQR_REQ: r_state <= S_SQR_WAIT;
                S_SQR_WAIT: begin
                    if (mp_out_valid) begin
                        r_acc <= mp_out_data;
                        if (r_exp_q[r_idx]) begin
                            r_mp_opA      <= mp_out_data;
                            r_mp_opB      <= r_base_q;
                            r_mp_in_valid <= 1'b1;
                            r_state       <= S_MUL_REQ;
                        end else if (r_idx == '0) begin
`ifdef MON_EXP_FROM_MONT_EN
                            r_mp_opA      <= mp_out_data;
                            r_mp_opB      <= ONE;
                            r_mp_in_valid <= 1'b1;
                            r_state       <= S_CONV_REQ;
`else
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_idx         <= r_idx - 1'b1;
                            r_mp_opA      <= mp_out_data;
                            r_mp_opB      <= mp_out_data;
                            r_mp_in_valid <= 1'b1;
                            r_state       <= S_SQR_REQ;
                        end
                    end
                end
                S_MUL_REQ: r_state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mp_out_valid) begin
                        r_acc <= mp_out_data;
                        if (r_idx == '0) begin
`ifdef MON_EXP_FROM_MONT_EN
                            r_mp_opA      <= mp_out_data;
                            r_mp_opB      <= ONE;
                            r_mp_in_valid <= 1'b1;
                            r_state       <= S_CONV_REQ;
`else
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
`endif
                        end else begin
                            r_idx         <= r_idx - 1'b1;
                            r_mp_opA      <= mp_out_data;
                            r_mp_opB      <= mp_out_data;
                            r_mp_in_valid <= 1'b1;
                            r_state       <= S_SQR_REQ;
                        end
                    end
                end
`ifdef MON_EXP_FROM_MONT_EN
                S_CONV_REQ: r_state <= S_CONV_WAIT;
                S_CONV_WAIT: begin
                    if (mp_out_valid) begin
                        r_acc   <= mp_out_data;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end
                end
`endif
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    // r_acc holds the final product throughout the DONE cycle; gate it so the
    // result port reads zero at all other times.
    assign result      = r_done ? r_acc : '0;
    assign mp_opA      = r_mp_opA;
    assign mp_opB      = r_mp_opB;
    assign mp_opM      = r_mp_opM;
    assign mp_in_valid = r_mp_in_valid;

endmodule
